alpha_beta_predictor: RTL and testbench
=======================================

Name: alpha_beta_predictor

Overview:
Fixed-point alpha-beta tracking predictor. Consumes the four phase strobes from the trigger sequencer (latch, update, predict, output) and, once per frame, produces a one-step-ahead prediction of the input sample stream. It is the consumer end of the trigger interface: it checks that the phase order is legal and flags violations.

Parameters:
DATA_W, 16, signed width of sample_in and prediction_out
FRAC_W, 8, fractional bits carried in the internal state
ALPHA_SHIFT, 1, position gain alpha = 2^-ALPHA_SHIFT
BETA_SHIFT, 3, velocity gain beta = 2^-BETA_SHIFT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
latch_trigger  in  1  phase 0 strobe
update_trigger  in  1  phase 1 strobe
predict_trigger  in  1  phase 2 strobe
output_trigger  in  1  phase 3 strobe
sample_in  in  DATA_W  signed input sample
prediction_out  out  DATA_W  signed registered prediction
out_valid  out  1  one-cycle pulse when prediction_out updates
sequence_error  out  1  one-cycle pulse on an illegal trigger

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Triggers are synchronous strobes sampled on the rising edge of clock. A strobe held for N cycles counts as N events.
- Internal state, signed, FRAC_W fractional bits, width DATA_W+FRAC_W+2:
  - sample_reg
  - x_hat
  - v_hat
  - x_pred
  - primed flag
- FSM states: WAIT_LATCH (reset state), WAIT_UPDATE, WAIT_PREDICT, WAIT_OUTPUT.
- WAIT_LATCH + latch only:
  - sample_reg <= sample_in << FRAC_W.
  - Go to WAIT_UPDATE.
- WAIT_UPDATE + update only:
  - If not primed: x_hat <= sample_reg, v_hat <= 0, primed <= 1.
  - Else: r = sample_reg - x_pred; x_hat <= x_pred + (r >>> ALPHA_SHIFT); v_hat <= v_hat + (r >>> BETA_SHIFT).
  - Go to WAIT_PREDICT.
- WAIT_PREDICT + predict only:
  - x_pred <= x_hat + v_hat.
  - Go to WAIT_OUTPUT.
- WAIT_OUTPUT + output only:
  - prediction_out <= sat(x_pred >>> FRAC_W).
  - out_valid pulses on the next cycle, i.e. 1 cycle after the output strobe.
  - Go to WAIT_LATCH.
- Shifts are arithmetic, so results floor toward -inf.
- sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- x_hat, v_hat and x_pred each saturate to the same range (scaled by 2^FRAC_W) on every write. No wrap-around is permitted.
- Illegal event: any trigger other than the expected one, or two or more triggers high in the same cycle.
  - sequence_error pulses for 1 cycle.
  - State goes to WAIT_LATCH.
  - No datapath register changes, and out_valid is not asserted.
- Resync exception: latch_trigger alone while in any state other than WAIT_LATCH.
  - sequence_error pulses.
  - The latch is performed and the state goes to WAIT_UPDATE.
- No trigger high: hold all state. out_valid = 0, sequence_error = 0.
- Reset (async, may occur mid-frame):
  - All internal registers, prediction_out, out_valid and sequence_error go to 0.
  - primed = 0; state = WAIT_LATCH.
  - The first complete frame after reset re-primes the filter.

Optional Feature:
PREDICTOR_ERR_COUNT_EN:
- When defined: adds output port error_count (8 bits). It increments on each sequence_error pulse, saturates at 255, resets to 0, and is cleared by a single-cycle strobe on an added input port error_clear. If increment and clear occur in the same cycle, the result is 0.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
All scenarios use DATA_W=16, FRAC_W=8, ALPHA_SHIFT=1, BETA_SHIFT=3, with one trigger per cycle in legal order.
1. Constant input: reset, then 4 legal frames with sample_in=100 -> prediction_out=100 after each frame; exactly 4 out_valid pulses; sequence_error never high.
2. Ramp: frame 1 sample 0 -> output 0; frame 2 sample 10 -> x_hat=5.0, v_hat=1.25, x_pred=6.25, output 6.
3. Saturation: prime with 0, then three frames of 32767 -> outputs 20479, 32255, then 32767 (clamped); no sign flip.
4. Out-of-order: latch, then predict_trigger -> sequence_error pulse; state WAIT_LATCH; prediction_out unchanged; no out_valid. Next legal frame completes normally.
5. Simultaneous triggers, and resync:
   - latch+update in the same cycle -> error; no register change.
   - latch alone in WAIT_PREDICT -> error pulse; the sample is latched and the frame continues from WAIT_UPDATE.
6. Reset mid-frame: assert reset between update and predict -> all outputs 0 immediately (async). The next frame with sample 50 re-primes and outputs 50. With PREDICTOR_ERR_COUNT_EN, 300 errors -> error_count=255, and error_clear -> 0.

Source files
------------

// File: rtl/alpha_beta_predictor.sv
// alpha_beta_predictor: fixed-point alpha-beta tracker.
// This block consumes the four phase strobes (latch, update, predict, output) and
// produces one one-step-ahead prediction per frame. It also flags any illegal
// phase order with a sequence_error pulse.
// The optional macro PREDICTOR_ERR_COUNT_EN adds an 8-bit saturating error counter.
// The counter comes with two extra ports: error_clear and error_count.
module alpha_beta_predictor #(
    parameter int DATA_W      = 16,
    parameter int FRAC_W      = 8,
    parameter int ALPHA_SHIFT = 1,
    parameter int BETA_SHIFT  = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     latch_trigger,
    input  logic                     update_trigger,
    input  logic                     predict_trigger,
    input  logic                     output_trigger,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic signed [DATA_W-1:0] prediction_out,
    output logic                     out_valid,
    output logic                     sequence_error
`ifdef PREDICTOR_ERR_COUNT_EN
    ,
    input  logic                     error_clear,
    output logic [7:0]               error_count
`endif
);

    // Internal state width: two guard bits above the scaled sample range.
    localparam int W  = DATA_W + FRAC_W + 2;
    // Extended width for intermediate sums, so they can never overflow before saturation.
    localparam int WE = W + 2;

    // Saturation limits for the state registers: the output range scaled by 2^FRAC_W.
    localparam logic signed [WE-1:0] ST_MAX_E =
        $signed({5'b00000, {(DATA_W-1){1'b1}}, {FRAC_W{1'b0}}});
    localparam logic signed [WE-1:0] ST_MIN_E =
        $signed({5'b11111, {(DATA_W-1){1'b0}}, {FRAC_W{1'b0}}});

    // Saturation limits for the integer output, expressed at state width.
    localparam logic signed [W-1:0] OUT_MAX =
        $signed({{(FRAC_W+3){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [W-1:0] OUT_MIN =
        $signed({{(FRAC_W+3){1'b1}}, {(DATA_W-1){1'b0}}});

    typedef enum logic [1:0] {
        WAIT_LATCH   = 2'd0,
        WAIT_UPDATE  = 2'd1,
        WAIT_PREDICT = 2'd2,
        WAIT_OUTPUT  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic signed [W-1:0] sample_reg;
    logic signed [W-1:0] x_hat;
    logic signed [W-1:0] v_hat;
    logic signed [W-1:0] x_pred;
    logic                primed;

    logic do_latch;
    logic do_update;
    logic do_predict;
    logic do_output;
    logic err_event;

    logic [3:0] trig;
    assign trig = {output_trigger, predict_trigger, update_trigger, latch_trigger};

    // Sign-extend a state value to the intermediate width.
    function automatic logic signed [WE-1:0] ext(input logic signed [W-1:0] v);
        return $signed({{2{v[W-1]}}, v});
    endfunction

    // Clamp an intermediate value into the scaled state range.
    function automatic logic signed [W-1:0] sat_state(input logic signed [WE-1:0] v);
        logic signed [WE-1:0] c;
        if (v > ST_MAX_E) begin
            c = ST_MAX_E;
        end else if (v < ST_MIN_E) begin
            c = ST_MIN_E;
        end else begin
            c = v;
        end
        return W'(c);
    endfunction

    // Drop the fraction (floor) and clamp to the signed output range.
    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] sh;
        logic signed [W-1:0] c;
        sh = v >>> FRAC_W;
        if (sh > OUT_MAX) begin
            c = OUT_MAX;
        end else if (sh < OUT_MIN) begin
            c = OUT_MIN;
        end else begin
            c = sh;
        end
        return DATA_W'(c);
    endfunction

    // Datapath arithmetic, evaluated at the extended width.
    logic signed [WE-1:0] resid_e;
    logic signed [WE-1:0] x_upd_e;
    logic signed [WE-1:0] v_upd_e;
    logic signed [WE-1:0] pred_e;
    logic signed [W-1:0]  sample_scaled;

    assign sample_scaled = $signed({{2{sample_in[DATA_W-1]}}, sample_in, {FRAC_W{1'b0}}});
    assign resid_e       = ext(sample_reg) - ext(x_pred);
    assign x_upd_e       = ext(x_pred) + (resid_e >>> ALPHA_SHIFT);
    assign v_upd_e       = ext(v_hat) + (resid_e >>> BETA_SHIFT);
    assign pred_e        = ext(x_hat) + ext(v_hat);

    // Phase state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= WAIT_LATCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    // A lone latch always resynchronises into WAIT_UPDATE.
    // Any other illegal event falls back to WAIT_LATCH.
    always_comb begin
        state_next = state_reg;
        case (trig)
            4'b0000: state_next = state_reg;
            4'b0001: state_next = WAIT_UPDATE;
            4'b0010: state_next = (state_reg == WAIT_UPDATE)  ? WAIT_PREDICT : WAIT_LATCH;
            4'b0100: state_next = (state_reg == WAIT_PREDICT) ? WAIT_OUTPUT  : WAIT_LATCH;
            4'b1000: state_next = WAIT_LATCH;
            default: state_next = WAIT_LATCH;
        endcase
    end

    // Decode phase actions and illegal events from the current state and strobes.
    always_comb begin
        do_latch   = 1'b0;
        do_update  = 1'b0;
        do_predict = 1'b0;
        do_output  = 1'b0;
        err_event  = 1'b0;
        case (trig)
            4'b0000: begin
            end
            4'b0001: begin
                do_latch  = 1'b1;
                err_event = (state_reg != WAIT_LATCH);
            end
            4'b0010: begin
                if (state_reg == WAIT_UPDATE) begin
                    do_update = 1'b1;
                end else begin
                    err_event = 1'b1;
                end
            end
            4'b0100: begin
                if (state_reg == WAIT_PREDICT) begin
                    do_predict = 1'b1;
                end else begin
                    err_event = 1'b1;
                end
            end
            4'b1000: begin
                if (state_reg == WAIT_OUTPUT) begin
                    do_output = 1'b1;
                end else begin
                    err_event = 1'b1;
                end
            end
            default: err_event = 1'b1;
        endcase
    end

    // Filter state registers.
    // Each register is written only in the phase that owns it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_reg <= '0;
            x_hat      <= '0;
            v_hat      <= '0;
            x_pred     <= '0;
            primed     <= 1'b0;
        end else begin
            if (do_latch) begin
                sample_reg <= sample_scaled;
            end
            if (do_update) begin
                if (!primed) begin
                    x_hat  <= sample_reg;
                    v_hat  <= '0;
                    primed <= 1'b1;
                end else begin
                    x_hat <= sat_state(x_upd_e);
                    v_hat <= sat_state(v_upd_e);
                end
            end
            if (do_predict) begin
                x_pred <= sat_state(pred_e);
            end
        end
    end

    // Registered output value with a valid pulse.
    // Both become visible in the cycle after the output strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prediction_out <= '0;
            out_valid      <= 1'b0;
        end else begin
            out_valid <= do_output;
            if (do_output) begin
                prediction_out <= sat_out(x_pred);
            end
        end
    end

    // One-cycle error pulse for each illegal event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sequence_error <= 1'b0;
        end else begin
            sequence_error <= err_event;
        end
    end

`ifdef PREDICTOR_ERR_COUNT_EN
    // Saturating error counter. A clear wins over a simultaneous increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_count <= 8'd0;
        end else if (error_clear) begin
            error_count <= 8'd0;
        end else if (err_event && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alpha_beta_predictor.sv
// Directed testbench for alpha_beta_predictor, using hand-computed expectations.
// If PREDICTOR_ERR_COUNT_EN is defined, the bench also exercises the error counter.
module tb_alpha_beta_predictor;

    logic               clock = 1'b0;
    logic               reset;
    logic               latch_trigger;
    logic               update_trigger;
    logic               predict_trigger;
    logic               output_trigger;
    logic signed [15:0] sample_in;
    logic signed [15:0] prediction_out;
    logic               out_valid;
    logic               sequence_error;
`ifdef PREDICTOR_ERR_COUNT_EN
    logic               error_clear;
    logic [7:0]         error_count;
`endif

    int tests  = 0;
    int fails  = 0;
    int ov_cnt = 0;
    int se_cnt = 0;
    logic last_ov;
    logic last_se;

    alpha_beta_predictor #(
        .DATA_W(16), .FRAC_W(8), .ALPHA_SHIFT(1), .BETA_SHIFT(3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .latch_trigger  (latch_trigger),
        .update_trigger (update_trigger),
        .predict_trigger(predict_trigger),
        .output_trigger (output_trigger),
        .sample_in      (sample_in),
        .prediction_out (prediction_out),
        .out_valid      (out_valid),
        .sequence_error (sequence_error)
`ifdef PREDICTOR_ERR_COUNT_EN
        ,
        .error_clear    (error_clear),
        .error_count    (error_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("[TB] ok %s = %0d", tag, observed);
        end
    endtask

    // Drive one cycle of strobes t = {output, predict, update, latch}.
    // Then sample the pulses that strobe produced.
    task automatic strobe(input logic [3:0] t, input logic signed [15:0] s);
        sample_in = s;
        {output_trigger, predict_trigger, update_trigger, latch_trigger} = t;
        @(posedge clock);
        #1;
        {output_trigger, predict_trigger, update_trigger, latch_trigger} = 4'b0000;
        last_ov = out_valid;
        last_se = sequence_error;
        if (out_valid) ov_cnt++;
        if (sequence_error) se_cnt++;
    endtask

    task automatic frame(input logic signed [15:0] s);
        strobe(4'b0001, s);
        strobe(4'b0010, s);
        strobe(4'b0100, s);
        strobe(4'b1000, s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        latch_trigger   = 1'b0;
        update_trigger  = 1'b0;
        predict_trigger = 1'b0;
        output_trigger  = 1'b0;
        sample_in       = '0;
`ifdef PREDICTOR_ERR_COUNT_EN
        error_clear     = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("reset_pred", prediction_out, 0);
        check("reset_valid", out_valid, 0);
        check("reset_err", sequence_error, 0);

        // Constant input: the filter primes on the first frame and then stays put.
        ov_cnt = 0;
        se_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            frame(16'sd100);
            check("const_pred", prediction_out, 100);
            check("const_valid", last_ov, 1);
        end
        @(posedge clock);
        #1;
        check("const_valid_cnt", ov_cnt, 4);
        check("const_err_cnt", se_cnt, 0);
        check("const_valid_drop", out_valid, 0);

        // Ramp: 0 then 10 gives x_hat=5.0, v_hat=1.25, x_pred=6.25, so the output is 6.
        do_reset();
        frame(16'sd0);
        check("ramp_f1", prediction_out, 0);
        frame(16'sd10);
        check("ramp_f2", prediction_out, 6);

        // Saturation at full scale.
        do_reset();
        frame(16'sd0);
        check("sat_prime", prediction_out, 0);
        frame(16'sd32767);
        check("sat_f1", prediction_out, 20479);
        frame(16'sd32767);
        check("sat_f2", prediction_out, 32255);
        frame(16'sd32767);
        check("sat_f3", prediction_out, 32767);

        // Out-of-order strobe.
        do_reset();
        frame(16'sd100);
        strobe(4'b0001, 16'sd7);
        check("ooo_latch_err", last_se, 0);
        strobe(4'b0100, 16'sd7);
        check("ooo_err", last_se, 1);
        check("ooo_valid", last_ov, 0);
        check("ooo_pred", prediction_out, 100);
        strobe(4'b0001, 16'sd100);
        check("ooo_back_to_latch", last_se, 0);
        strobe(4'b0010, 16'sd100);
        strobe(4'b0100, 16'sd100);
        strobe(4'b1000, 16'sd100);
        check("ooo_recover_pred", prediction_out, 100);
        check("ooo_recover_valid", last_ov, 1);
        strobe(4'b1000, 16'sd0);
        check("out_in_latch_err", last_se, 1);
        check("out_in_latch_valid", last_ov, 0);

        // Simultaneous strobes must leave the datapath untouched.
        strobe(4'b0011, 16'sd9999);
        check("multi_lu_err", last_se, 1);
        strobe(4'b0001, 16'sd200);
        strobe(4'b0110, 16'sd200);
        check("multi_up_err", last_se, 1);
        frame(16'sd100);
        check("multi_pred", prediction_out, 100);

        // Resync: a lone latch while in WAIT_PREDICT relatches and continues.
        // Expected result: x_hat=150, v_hat=12.5, x_pred=162.5 -> 162.
        strobe(4'b0001, 16'sd100);
        strobe(4'b0010, 16'sd100);
        strobe(4'b0001, 16'sd200);
        check("resync_err", last_se, 1);
        strobe(4'b0010, 16'sd200);
        check("resync_update_ok", last_se, 0);
        strobe(4'b0100, 16'sd200);
        strobe(4'b1000, 16'sd200);
        check("resync_pred", prediction_out, 162);
        check("resync_valid", last_ov, 1);

        // Asynchronous reset mid-frame, asserted between update and predict.
        strobe(4'b0001, 16'sd100);
        strobe(4'b0010, 16'sd100);
        #2;
        reset = 1'b1;
        #1;
        check("async_pred", prediction_out, 0);
        check("async_valid", out_valid, 0);
        check("async_err", sequence_error, 0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        frame(16'sd50);
        check("reprime_f1", prediction_out, 50);
        frame(16'sd50);
        check("reprime_f2", prediction_out, 50);

`ifdef PREDICTOR_ERR_COUNT_EN
        do_reset();
        check("cnt_reset", error_count, 0);
        for (int i = 0; i < 300; i++) begin
            strobe(4'b1000, 16'sd0);
        end
        check("cnt_sat", error_count, 255);
        error_clear = 1'b1;
        @(posedge clock);
        #1;
        error_clear = 1'b0;
        check("cnt_clear", error_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
